mips_decode_stage: RTL and testbench
====================================

Name: mips_decode_stage

Overview:
Registered, parametrised decode stage for the MIPS arithmetic/logic datapath.
- Accepts a full 32-bit instruction over a valid/ready handshake.
- Decodes add, addi, sub, and, andi, or, ori, nor, xor and xori.
- Presents registered control signals, register indices and the extended immediate to the execute stage.
- Adds what a purely combinational decoder lacks: backpressure, a configurable data width, an optional halt-on-exception mode and a saturating exception counter.

Parameters:
DATA_WIDTH, 32, width of imm_ext; must be >= 16.
STRICT, 1, 1 = halt intake after an excepting instruction until clear_halt; 0 = pass excepting instructions and keep running.
CNT_WIDTH, 8, width of the saturating exception counter.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
inst  in  32  instruction word
in_valid  in  1  inst is valid
in_ready  out  1  stage can accept inst this cycle
out_ready  in  1  downstream accepts output this cycle
out_valid  out  1  output register holds a decoded instruction
rd_src  out  1  0 = destination rd, 1 = destination rt
writeenable  out  1  instruction writes the register file
except  out  1  opcode/funct combination not recognised
alu_src2  out  2  00 = register, 01 = sign-extended imm, 10 = zero-extended imm
alu_op  out  3  ALU control
rs, rt, rd  out  5 each  register fields inst[25:21], inst[20:16], inst[15:11]
w_addr  out  5  rt if rd_src else rd; 0 when except
imm_ext  out  DATA_WIDTH  inst[15:0] extended per alu_src2; 0 for register forms
halted  out  1  stage is in HALT
clear_halt  in  1  single-cycle pulse that leaves HALT
exc_count  out  CNT_WIDTH  number of excepting instructions accepted, saturating

Behaviour:
- Encodings:
  - Opcodes: R-type = 0x00, addi = 0x08, andi = 0x0C, ori = 0x0D, xori = 0x0E.
  - R-type funct: add = 0x20, sub = 0x22, and = 0x24, or = 0x25, xor = 0x26, nor = 0x27.
- alu_op per instruction: add/addi = 010, sub = 011, and/andi = 100, or/ori = 101, nor = 110, xor/xori = 111.
- alu_src2 per instruction: addi = 01; andi/ori/xori = 10; R-type = 00.
- rd_src = 1 for the immediate forms only.
- Excepting instructions (any other opcode/funct): except = 1, writeenable = 0, alu_op = 000, alu_src2 = 00, rd_src = 0, w_addr = 0, imm_ext = 0. rs/rt/rd still carry the raw fields.
- Decode is combinational from inst. All outputs except in_ready are registered. Latency is 1 cycle from the accept edge to out_valid.
- Accept condition: in_valid & in_ready at a rising edge.
  - in_ready = ~halted & (~out_valid | out_ready).
- Output register update:
  - On accept: load the decoded fields and set out_valid = 1.
  - Otherwise, if out_ready & out_valid: clear out_valid.
  - While out_valid & ~out_ready: every output field is held stable.
- Simultaneous drain and accept in the same cycle loads the new word with no bubble. Full throughput is 1 instruction per cycle.
- State machine: RUN and HALT.
  - RUN -> HALT: on accept of an excepting instruction when STRICT = 1. That instruction is still delivered with except = 1.
  - HALT -> RUN: on clear_halt = 1. in_ready may assert in the following cycle.
  - In HALT, in_ready = 0. Delivery of an already-registered output still completes normally.
  - clear_halt in RUN has no effect.
  - STRICT = 0: the state machine stays in RUN permanently.
  - halted = (state == HALT).
- exc_count increments by 1 on each accept of an excepting instruction and saturates at 2^CNT_WIDTH - 1. It is cleared only by reset.
- Reset (reset = 0 at an edge), including mid-transfer or while in HALT:
  - out_valid = 0, state = RUN, exc_count = 0.
  - All data outputs = 0.
  - in_ready = 0 during reset, and 1 in the first cycle after reset is released.
  - A word offered during reset is dropped.
- Zero extension fills the upper DATA_WIDTH-16 bits with 0. Sign extension replicates inst[15].

Test Plan:
- Reset then inst = 0x2128FFFF (addi $8,$9,-1), out_ready = 1 -> next cycle: out_valid = 1, alu_op = 010, alu_src2 = 01, rd_src = 1, w_addr = 8, rs = 9, imm_ext = 0xFFFFFFFF, writeenable = 1, except = 0.
- inst = 0x3528FFFF (ori) -> alu_op = 101, alu_src2 = 10, imm_ext = 0x0000FFFF. inst = 0x01095020 (add $10,$8,$9) -> alu_op = 010, alu_src2 = 00, rd_src = 0, w_addr = 10, imm_ext = 0.
- Backpressure:
  - Stream 3 valid words with out_ready = 0 for 4 cycles: the first word is held stable, in_ready = 0 after the first accept, and no word is lost or duplicated.
  - Then out_ready = 1: words delivered in order on consecutive cycles.
- STRICT = 1: inst = 0xFC000000 -> except = 1, writeenable = 0, w_addr = 0, exc_count = 1, halted = 1, in_ready stays 0. Pulse clear_halt -> halted = 0, in_ready = 1 the next cycle.
- STRICT = 0, CNT_WIDTH = 2: 5 consecutive illegal words -> all delivered with except = 1, halted stays 0, exc_count sequence 1,2,3,3,3.
- Assert reset = 0 while out_valid = 1, out_ready = 0, in HALT -> next cycle: out_valid = 0, halted = 0, exc_count = 0, all outputs 0.

Source files
------------

// File: rtl/mips_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
interface mips_decode_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic [31:0]           inst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_ready;
  logic                  out_valid;
  logic                  rd_src;
  logic                  writeenable;
  logic                  except;
  logic [1:0]            alu_src2;
  logic [2:0]            alu_op;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            w_addr;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic                  halted;
  logic                  clear_halt;
  logic [CNT_WIDTH-1:0]  exc_count;

  modport slave (
    input  inst, in_valid, out_ready, clear_halt,
    output in_ready, out_valid, rd_src, writeenable, except, alu_src2, alu_op,
           rs, rt, rd, w_addr, imm_ext, halted, exc_count
  );

  modport master (
    output inst, in_valid, out_ready, clear_halt,
    input  in_ready, out_valid, rd_src, writeenable, except, alu_src2, alu_op,
           rs, rt, rd, w_addr, imm_ext, halted, exc_count
  );
endinterface

// File: rtl/mips_decode_stage.sv
// Registered MIPS ALU-instruction decode stage with valid/ready flow control,
// optional halt-on-exception and a saturating exception counter.
module mips_decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter bit STRICT     = 1'b1,
  parameter int CNT_WIDTH  = 8
) (
  input logic               clock,
  input logic               reset,
  mips_decode_stage_if.slave bus
);

  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_SEXT = 2'b01;
  localparam logic [1:0] SRC_ZEXT = 2'b10;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [4:0]            f_rs;
  logic [4:0]            f_rt;
  logic [4:0]            f_rd;
  logic [15:0]           f_imm;

  logic                  d_legal;
  logic [2:0]            d_op;
  logic [1:0]            d_src2;
  logic                  d_rd_src;
  logic [4:0]            d_waddr;
  logic [DATA_WIDTH-1:0] d_imm;

  logic                  state;
  logic                  valid_q;
  logic                  rd_src_q;
  logic                  we_q;
  logic                  except_q;
  logic [1:0]            src2_q;
  logic [2:0]            op_q;
  logic [4:0]            rs_q;
  logic [4:0]            rt_q;
  logic [4:0]            rd_q;
  logic [4:0]            waddr_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  ready;
  logic                  accept;
  logic                  accept_exc;

  assign opcode = bus.inst[31:26];
  assign f_rs   = bus.inst[25:21];
  assign f_rt   = bus.inst[20:16];
  assign f_rd   = bus.inst[15:11];
  assign f_imm  = bus.inst[15:0];
  assign funct  = bus.inst[5:0];

  always_comb begin
    d_legal = 1'b1;
    d_op    = 3'b000;
    d_src2  = SRC_REG;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   d_op = 3'b010;
          F_SUB:   d_op = 3'b011;
          F_AND:   d_op = 3'b100;
          F_OR:    d_op = 3'b101;
          F_NOR:   d_op = 3'b110;
          F_XOR:   d_op = 3'b111;
          default: d_legal = 1'b0;
        endcase
      end
      OP_ADDI: begin d_op = 3'b010; d_src2 = SRC_SEXT; end
      OP_ANDI: begin d_op = 3'b100; d_src2 = SRC_ZEXT; end
      OP_ORI:  begin d_op = 3'b101; d_src2 = SRC_ZEXT; end
      OP_XORI: begin d_op = 3'b111; d_src2 = SRC_ZEXT; end
      default: d_legal = 1'b0;
    endcase
  end

  always_comb begin
    d_rd_src = (d_src2 != SRC_REG);
    d_waddr  = '0;
    if (d_legal)
      d_waddr = d_rd_src ? f_rt : f_rd;
    case (d_src2)
      SRC_SEXT: d_imm = DATA_WIDTH'($signed(f_imm));
      SRC_ZEXT: d_imm = DATA_WIDTH'(f_imm);
      default:  d_imm = '0;
    endcase
  end

  // Reset gates in_ready so a word offered while reset is low is never accepted.
  assign ready      = reset & (state == RUN) & (~valid_q | bus.out_ready);
  assign accept     = bus.in_valid & ready;
  assign accept_exc = accept & ~d_legal;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      rd_src_q <= 1'b0;
      we_q     <= 1'b0;
      except_q <= 1'b0;
      src2_q   <= '0;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      waddr_q  <= '0;
      imm_q    <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      rd_src_q <= d_rd_src;
      we_q     <= d_legal;
      except_q <= ~d_legal;
      src2_q   <= d_src2;
      op_q     <= d_op;
      rs_q     <= f_rs;
      rt_q     <= f_rt;
      rd_q     <= f_rd;
      waddr_q  <= d_waddr;
      imm_q    <= d_imm;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept_exc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (accept_exc && STRICT) state <= HALT;
        HALT:    if (bus.clear_halt) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.rd_src      = rd_src_q;
  assign bus.writeenable = we_q;
  assign bus.except      = except_q;
  assign bus.alu_src2    = src2_q;
  assign bus.alu_op      = op_q;
  assign bus.rs          = rs_q;
  assign bus.rt          = rt_q;
  assign bus.rd          = rd_q;
  assign bus.w_addr      = waddr_q;
  assign bus.imm_ext     = imm_q;
  assign bus.halted      = (state == HALT);
  assign bus.exc_count   = cnt_q;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Randomized bench for two mips_decode_stage builds (strict/32-bit, lenient/16-bit/2-bit count)
// checked every cycle against a table-driven reference of the decode stage.
module tb_mips_decode_stage;

  typedef struct packed {
    logic        exc;
    logic        we;
    logic        rds;
    logic [1:0]  src2;
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  wa;
    logic [31:0] imm;
  } dec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mips_decode_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) b0 ();
  mips_decode_stage_if #(.DATA_WIDTH(16), .CNT_WIDTH(2)) b1 ();

  mips_decode_stage #(.DATA_WIDTH(32), .STRICT(1'b1), .CNT_WIDTH(8)) u0 (
    .clock(clock), .reset(reset), .bus(b0.slave));
  mips_decode_stage #(.DATA_WIDTH(16), .STRICT(1'b0), .CNT_WIDTH(2)) u1 (
    .clock(clock), .reset(reset), .bus(b1.slave));

  // model state per instance: 0 = strict/8-bit count, 1 = lenient/2-bit count
  dec_t mf[2];
  bit   mv[2];
  bit   mh[2];
  int   mc[2];
  int   cmax[2]   = '{255, 3};
  bit   strict[2] = '{1'b1, 1'b0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t    d;
    int      opc;
    int      fn;
    int      aop;
    int      kind;
    bit      legal;
    shortint s;
    d     = '0;
    opc   = int'(w[31:26]);
    fn    = int'(w[5:0]);
    legal = 1'b1;
    kind  = 0;
    aop   = 0;
    d.rs  = w[25:21];
    d.rt  = w[20:16];
    d.rd  = w[15:11];
    if (opc == 0) begin
      case (fn)
        'h20: aop = 2;
        'h22: aop = 3;
        'h24: aop = 4;
        'h25: aop = 5;
        'h26: aop = 7;
        'h27: aop = 6;
        default: legal = 1'b0;
      endcase
    end else if (opc == 'h08) begin aop = 2; kind = 1;
    end else if (opc == 'h0C) begin aop = 4; kind = 2;
    end else if (opc == 'h0D) begin aop = 5; kind = 2;
    end else if (opc == 'h0E) begin aop = 7; kind = 2;
    end else legal = 1'b0;
    d.exc = !legal;
    if (legal) begin
      s      = shortint'(w[15:0]);
      d.we   = 1'b1;
      d.op   = 3'(aop);
      d.src2 = 2'(kind);
      d.rds  = (kind != 0);
      d.wa   = d.rds ? d.rt : d.rd;
      if (kind == 1) d.imm = 32'(int'(s));
      else if (kind == 2) d.imm = 32'(w[15:0]);
    end
    return d;
  endfunction

  task automatic compare_all();
    dec_t o[2];
    bit   ov[2];
    bit   oh[2];
    int   oc[2];
    o[0] = '{exc: b0.except, we: b0.writeenable, rds: b0.rd_src, src2: b0.alu_src2,
             op: b0.alu_op, rs: b0.rs, rt: b0.rt, rd: b0.rd, wa: b0.w_addr, imm: b0.imm_ext};
    o[1] = '{exc: b1.except, we: b1.writeenable, rds: b1.rd_src, src2: b1.alu_src2,
             op: b1.alu_op, rs: b1.rs, rt: b1.rt, rd: b1.rd, wa: b1.w_addr, imm: 32'(b1.imm_ext)};
    ov[0] = b0.out_valid; ov[1] = b1.out_valid;
    oh[0] = b0.halted;    oh[1] = b1.halted;
    oc[0] = int'(b0.exc_count); oc[1] = int'(b1.exc_count);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.out_valid", k), ov[k], mv[k]);
      check($sformatf("u%0d.halted", k), oh[k], mh[k]);
      check($sformatf("u%0d.exc_count", k), oc[k], mc[k]);
      check($sformatf("u%0d.except", k), o[k].exc, mf[k].exc);
      check($sformatf("u%0d.writeenable", k), o[k].we, mf[k].we);
      check($sformatf("u%0d.rd_src", k), o[k].rds, mf[k].rds);
      check($sformatf("u%0d.alu_src2", k), o[k].src2, mf[k].src2);
      check($sformatf("u%0d.alu_op", k), o[k].op, mf[k].op);
      check($sformatf("u%0d.rs_rt_rd", k), {o[k].rs, o[k].rt, o[k].rd}, {mf[k].rs, mf[k].rt, mf[k].rd});
      check($sformatf("u%0d.w_addr", k), o[k].wa, mf[k].wa);
      check($sformatf("u%0d.imm_ext", k), o[k].imm,
            (k == 1) ? (mf[k].imm & 32'h0000FFFF) : mf[k].imm);
    end
  endtask

  // One cycle: drive inputs just after a negedge, advance the model, compare at the next negedge.
  task automatic cycle(input bit r, input bit v, input logic [31:0] w, input bit o, input bit c,
                       output bit acc0);
    bit rdy[2];
    bit was_h;
    reset = r;
    b0.inst = w; b0.in_valid = v; b0.out_ready = o; b0.clear_halt = c;
    b1.inst = w; b1.in_valid = v; b1.out_ready = o; b1.clear_halt = c;
    #1;
    for (int k = 0; k < 2; k++)
      rdy[k] = r && !mh[k] && (!mv[k] || o);
    check("u0.in_ready", b0.in_ready, rdy[0]);
    check("u1.in_ready", b1.in_ready, rdy[1]);
    acc0 = v && rdy[0];
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        mv[k] = 1'b0; mh[k] = 1'b0; mc[k] = 0; mf[k] = '0;
      end else begin
        was_h = mh[k];
        if (v && rdy[k]) begin
          mf[k] = ref_decode(w);
          mv[k] = 1'b1;
          if (mf[k].exc) begin
            if (mc[k] < cmax[k]) mc[k]++;
            if (strict[k]) mh[k] = 1'b1;
          end
        end else if (o) begin
          mv[k] = 1'b0;
        end
        if (was_h && c) mh[k] = 1'b0;
      end
    end
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          ops[5] = '{0, 'h08, 'h0C, 'h0D, 'h0E};
    int          fns[6] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27};
    w = $urandom;
    if ($urandom_range(0, 15) < 12) begin
      w[31:26] = 6'(ops[$urandom_range(0, 4)]);
      if (w[31:26] == 6'd0) w[5:0] = 6'(fns[$urandom_range(0, 5)]);
    end
    return w;
  endfunction

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] words[3] = '{32'h20240005, 32'h344500F0, 32'h00663826};
    logic [31:0] bad[5]   = '{32'hFC000000, 32'h0000003F, 32'h04000000, 32'h00000021, 32'h3C000000};
    int          seq[5]   = '{1, 2, 3, 3, 3};

    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; mh[k] = 1'b0; mc[k] = 0; mf[k] = '0;
    end
    b0.inst = '0; b0.in_valid = 1'b0; b0.out_ready = 1'b0; b0.clear_halt = 1'b0;
    b1.inst = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.clear_halt = 1'b0;
    @(negedge clock);

    // reset with a word offered: dropped
    cycle(0, 1, 32'h2128FFFF, 1, 0, acc);
    cycle(0, 1, 32'h2128FFFF, 1, 0, acc);
    check("rst_out_valid", b0.out_valid, 0);

    // addi $8,$9,-1
    cycle(1, 1, 32'h2128FFFF, 1, 0, acc);
    check("addi_valid", b0.out_valid, 1);
    check("addi_alu_op", b0.alu_op, 3'b010);
    check("addi_src2", b0.alu_src2, 2'b01);
    check("addi_rd_src", b0.rd_src, 1);
    check("addi_w_addr", b0.w_addr, 8);
    check("addi_rs", b0.rs, 9);
    check("addi_imm", b0.imm_ext, 32'hFFFFFFFF);
    check("addi_we_exc", {b0.writeenable, b0.except}, 2'b10);
    cycle(1, 1, 32'h3528FFFF, 1, 0, acc);
    check("ori_alu_op", b0.alu_op, 3'b101);
    check("ori_src2", b0.alu_src2, 2'b10);
    check("ori_imm", b0.imm_ext, 32'h0000FFFF);
    cycle(1, 1, 32'h01095020, 1, 0, acc);
    check("add_alu_op", b0.alu_op, 3'b010);
    check("add_src2", b0.alu_src2, 2'b00);
    check("add_rd_src", b0.rd_src, 0);
    check("add_w_addr", b0.w_addr, 10);
    check("add_imm", b0.imm_ext, 0);
    cycle(1, 0, 32'h0, 1, 0, acc);

    // backpressure: 4 stalled cycles, then release
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, words[idx], 0, 0, acc);
      if (acc) idx++;
      check("bp_held_rs", b0.rs, 1);
      check("bp_held_wa", b0.w_addr, 4);
    end
    check("bp_accepted_once", idx, 1);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, words[idx], 1, 0, acc);
      if (acc) idx++;
      check("bp_order_rs", b0.rs, 5'(i + 2));
    end
    cycle(1, 0, 32'h0, 1, 0, acc);
    check("bp_drained", b0.out_valid, 0);

    // strict halt and clear
    cycle(1, 1, 32'hFC000000, 1, 0, acc);
    check("halt_except", b0.except, 1);
    check("halt_we", b0.writeenable, 0);
    check("halt_w_addr", b0.w_addr, 0);
    check("halt_count", b0.exc_count, 1);
    check("halt_halted", b0.halted, 1);
    cycle(1, 1, 32'h2128FFFF, 1, 0, acc);
    cycle(1, 1, 32'h2128FFFF, 1, 1, acc);
    check("clear_halted", b0.halted, 0);
    #1;
    check("clear_in_ready", b0.in_ready, 1);

    // lenient build: saturating count
    cycle(0, 0, 32'h0, 1, 0, acc);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, bad[i], 1, 0, acc);
      check("lenient_count", b1.exc_count, seq[i]);
      check("lenient_halted", b1.halted, 0);
      check("lenient_except", {b1.out_valid, b1.except}, 2'b11);
    end

    // reset while holding an undelivered word in HALT
    cycle(0, 0, 32'h0, 1, 0, acc);
    cycle(1, 1, 32'hFC000000, 0, 0, acc);
    cycle(1, 1, 32'h2128FFFF, 0, 0, acc);
    check("pre_rst_state", {b0.out_valid, b0.halted}, 2'b11);
    cycle(0, 1, 32'h2128FFFF, 0, 0, acc);
    check("rst_valid_halt", {b0.out_valid, b0.halted}, 2'b00);
    check("rst_count", b0.exc_count, 0);
    check("rst_fields", {b0.except, b0.writeenable, b0.rd_src, b0.alu_src2, b0.alu_op,
                         b0.rs, b0.rt, b0.rd, b0.w_addr}, 0);
    check("rst_imm", b0.imm_ext, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, rand_inst(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
